rvlab_mmcm_reconfig_ctrl: RTL and testbench
===========================================

Name: rvlab_mmcm_reconfig_ctrl

Overview:
Sequences run-time reconfiguration of the system MMCM through its DRP port. On request it holds the MMCM in reset and applies one of NUM_CFG preset register tables via read-modify-write DRP transactions. It then releases reset and waits for a stable LOCKED. It runs on the free-running buffered 100 MHz input clock, never on an MMCM output, and sits beside the clock manager at FPGA top level.

Parameters:
NUM_CFG, 2, number of preset configurations in the package table
NUM_REGS, 8, DRP register entries per configuration
DRP_TIMEOUT, 64, max cycles from den pulse to drdy before error
LOCK_STABLE, 16, cycles LOCKED must stay continuously high to count as locked
LOCK_TIMEOUT, 100000, max cycles after reset release to reach stable lock before error

Ports:
clk_i  in  1  buffered 100 MHz clock
rst_ni  in  1  asynchronous reset, active low
start_i  in  1  request reconfiguration; sampled only in IDLE
cfg_sel_i  in  $clog2(NUM_CFG) (min 1)  configuration index, latched with start_i
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse on successful completion
err_o  out  1  last sequence failed; held until next accepted start
mmcm_rst_o  out  1  to MMCM RST
drp_den_o  out  1  DRP enable, one-cycle pulse
drp_dwe_o  out  1  DRP write enable, high only with den on writes
drp_daddr_o  out  7  DRP address
drp_di_o  out  16  DRP write data
drp_do_i  in  16  DRP read data
drp_drdy_i  in  1  DRP ready
mmcm_locked_i  in  1  MMCM LOCKED (asynchronous; 2-FF synchronised internally)

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-sequence aborts at once. mmcm_rst_o drops, so the MMCM relocks on whatever register contents it holds.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, WAIT_LOCK, DONE, FAIL.
- IDLE: start_i=1 latches cfg_sel_i and clears err_o.
  - If cfg_sel_i >= NUM_CFG, go to FAIL with no DRP access.
  - Otherwise go to RD_REQ with entry index 0. busy_o and mmcm_rst_o are 1 from the next cycle.
- start_i outside IDLE is ignored.
- RD_REQ: one cycle with den=1, dwe=0, daddr=entry.addr. Then RD_WAIT.
- RD_WAIT: on drdy, capture new = (drp_do_i & entry.mask) | entry.data. Mask bit 1 = retain. Then WR_REQ.
- WR_REQ: one cycle with den=1, dwe=1, daddr=entry.addr, di=new. Then WR_WAIT.
- WR_WAIT: on drdy, go to NEXT.
- NEXT: index==NUM_REGS-1 → WAIT_LOCK and mmcm_rst_o=0. Otherwise increment index → RD_REQ.
- DRP timeout: RD_WAIT/WR_WAIT count cycles from 0 after den. Reaching DRP_TIMEOUT without drdy → FAIL. No new den is issued while a transaction is outstanding.
- drdy outside a wait state is ignored.
- WAIT_LOCK:
  - The stability counter increments while synced locked=1 and resets to 0 on locked=0.
  - When it reaches LOCK_STABLE → DONE.
  - The global lock timer reaching LOCK_TIMEOUT first → FAIL.
  - LOCKED held high throughout yields DONE exactly LOCK_STABLE+2 cycles after mmcm_rst_o falls (sync latency 2).
- DONE: done_o=1 for one cycle, busy_o=0 next cycle, → IDLE.
- FAIL: err_o=1 (sticky), mmcm_rst_o=0, busy_o=0, no done_o, → IDLE.
- Minimum per-entry cost is 4 cycles plus DRP latency. No back-to-back den across entries.

Decomposition:
- Package rvlab_clk_pkg holds:
  - drp_entry_t = struct {addr 7b, mask 16b, data 16b}.
  - constant MMCM_CFG_TABLE[NUM_CFG][NUM_REGS] of drp_entry_t. Entry 0 = 50/200 MHz, entry 1 = 25/200 MHz.
  - DRP address constants (CLKOUT0/1 reg1/reg2, CLKFBOUT, DIVCLK, LOCK, FILT).
- One sub-module, rvlab_lock_monitor: the synchroniser, stability counter and timeout. Outputs lock_ok and lock_timeout; cleared by an enable input.

Test Plan:
- Nominal: cfg_sel=0, start pulse, DRP model answers drdy 3 cycles after den, LOCKED high 40 cycles after rst release. Expect 8 reads and 8 writes, each write di = (old & mask) | data per table. mmcm_rst_o high over all DRP traffic, single done_o pulse, err_o=0.
- Lock glitch: LOCKED rises, drops after 10 cycles, rises again. Expect done_o exactly LOCK_STABLE+2 cycles after the final rise.
- DRP hang: model never asserts drdy on entry 2 read. Expect err_o=1 at cycle DRP_TIMEOUT after that den, mmcm_rst_o=0, no further den, no done_o.
- Invalid selection: NUM_CFG=2, cfg_sel=1 OK; with a 2-bit bench override cfg_sel=3. Expect immediate err_o=1, zero DRP transactions.
- Start while busy: second start mid-sequence with a different cfg_sel. Expect it ignored and the first table written unchanged. start after done is accepted and clears err_o.
- Reset mid-op: assert rst_ni during WR_WAIT of entry 4. Expect all outputs 0 asynchronously, IDLE after release, new start performs a full 8-entry sequence.

Source files
------------

// File: rtl/rvlab_clk_pkg.sv
// MMCM reconfiguration types, DRP register map and preset tables.
// Table rows are read-modify-write entries: mask bit 1 keeps the old bit.
package rvlab_clk_pkg;

  localparam int MMCM_NUM_CFG  = 2;
  localparam int MMCM_NUM_REGS = 8;

  localparam logic [6:0] DRP_CLKOUT0_R1 = 7'h08;
  localparam logic [6:0] DRP_CLKOUT0_R2 = 7'h09;
  localparam logic [6:0] DRP_CLKOUT1_R1 = 7'h0A;
  localparam logic [6:0] DRP_CLKOUT1_R2 = 7'h0B;
  localparam logic [6:0] DRP_CLKFBOUT   = 7'h14;
  localparam logic [6:0] DRP_DIVCLK     = 7'h16;
  localparam logic [6:0] DRP_LOCK1      = 7'h18;
  localparam logic [6:0] DRP_FILT1      = 7'h4E;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  // VCO 1000 MHz: cfg0 CLKOUT0 /20 = 50 MHz, cfg1 /40 = 25 MHz;
  // CLKOUT1 /5 = 200 MHz in both.
  localparam drp_entry_t MMCM_CFG_TABLE
    [MMCM_NUM_CFG][MMCM_NUM_REGS] = '{
    '{
      '{DRP_CLKOUT0_R1, 16'h1000, 16'h028A},
      '{DRP_CLKOUT0_R2, 16'hFC00, 16'h0000},
      '{DRP_CLKOUT1_R1, 16'h1000, 16'h0083},
      '{DRP_CLKOUT1_R2, 16'hFC00, 16'h0080},
      '{DRP_CLKFBOUT,   16'h1000, 16'h0145},
      '{DRP_DIVCLK,     16'hC000, 16'h1041},
      '{DRP_LOCK1,      16'hFC00, 16'h03E8},
      '{DRP_FILT1,      16'h66FF, 16'h0800}
    },
    '{
      '{DRP_CLKOUT0_R1, 16'h1000, 16'h0514},
      '{DRP_CLKOUT0_R2, 16'hFC00, 16'h0000},
      '{DRP_CLKOUT1_R1, 16'h1000, 16'h0083},
      '{DRP_CLKOUT1_R2, 16'hFC00, 16'h0080},
      '{DRP_CLKFBOUT,   16'h1000, 16'h0145},
      '{DRP_DIVCLK,     16'hC000, 16'h1041},
      '{DRP_LOCK1,      16'hFC00, 16'h03E8},
      '{DRP_FILT1,      16'h66FF, 16'h0800}
    }
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_NEXT,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_FAIL
  } rcfg_state_e;

  function automatic logic [15:0] drp_merge(
    input logic [15:0] rd,
    input drp_entry_t  e
  );
    return (rd & e.mask) | e.data;
  endfunction

endpackage

// File: rtl/rvlab_lock_monitor.sv
// LOCKED synchroniser with stability counter and lock timeout.
// Everything is held cleared while en_i is low.
module rvlab_lock_monitor
  import rvlab_clk_pkg::*;
#(
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic locked_i,
  output logic lock_ok_o,
  output logic lock_timeout_o
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic [1:0]    sync_q, sync_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tmr_q, tmr_d;

  // Next-state for synchroniser, stability run and timeout timer.
  always_comb begin
    sync_d = 2'b00;
    stab_d = '0;
    tmr_d  = '0;
    if (en_i) begin
      sync_d = {sync_q[0], locked_i};
      if (sync_q[1] && stab_q != SW'(LOCK_STABLE))
        stab_d = stab_q + 1'b1;
      else if (sync_q[1])
        stab_d = stab_q;
      if (tmr_q != TW'(LOCK_TIMEOUT))
        tmr_d = tmr_q + 1'b1;
      else
        tmr_d = tmr_q;
    end
  end

  // Monitor state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      stab_q <= '0;
      tmr_q  <= '0;
    end else begin
      sync_q <= sync_d;
      stab_q <= stab_d;
      tmr_q  <= tmr_d;
    end
  end

  assign lock_ok_o = en_i && sync_q[1] &&
                     stab_q == SW'(LOCK_STABLE - 1);
  assign lock_timeout_o = en_i &&
                          tmr_q == TW'(LOCK_TIMEOUT - 1);

endmodule

// File: rtl/rvlab_mmcm_reconfig_ctrl.sv
// MMCM DRP reconfiguration sequencer: holds the MMCM in reset,
// rewrites one preset table by read-modify-write, then waits for lock.
module rvlab_mmcm_reconfig_ctrl
  import rvlab_clk_pkg::*;
#(
  parameter int NUM_CFG      = MMCM_NUM_CFG,
  parameter int NUM_REGS     = MMCM_NUM_REGS,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int SEL_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [SEL_W-1:0] cfg_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             mmcm_rst_o,
  output logic             drp_den_o,
  output logic             drp_dwe_o,
  output logic [6:0]       drp_daddr_o,
  output logic [15:0]      drp_di_o,
  input  logic [15:0]      drp_do_i,
  input  logic             drp_drdy_i,
  input  logic             mmcm_locked_i
);

  localparam int CW  = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DCW = $clog2(DRP_TIMEOUT + 1);
  localparam logic [31:0] NUM_CFG_U = NUM_CFG;

  rcfg_state_e    state_q, state_d;
  logic [CW-1:0]  cfg_q, cfg_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           err_q, err_d;
  logic           mmcm_rst_q, mmcm_rst_d;
  logic           den, dwe;
  logic           lock_ok, lock_to;
  drp_entry_t     entry;

  assign entry = MMCM_CFG_TABLE[cfg_q][idx_q];

  rvlab_lock_monitor #(
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (state_q == ST_WAIT_LOCK),
    .locked_i      (mmcm_locked_i),
    .lock_ok_o     (lock_ok),
    .lock_timeout_o(lock_to)
  );

  // Sequencer next-state and DRP strobes.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    den     = 1'b0;
    dwe     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cfg_d = cfg_sel_i[CW-1:0];
          err_d = 1'b0;
          idx_d = '0;
          if (32'(cfg_sel_i) >= NUM_CFG_U)
            state_d = ST_FAIL;
          else
            state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        den     = 1'b1;
        dcnt_d  = DCW'(1);
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (drp_drdy_i) begin
          wdata_d = drp_merge(drp_do_i, entry);
          state_d = ST_WR_REQ;
        end else if (dcnt_q == DCW'(DRP_TIMEOUT - 1)) begin
          state_d = ST_FAIL;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_WR_REQ: begin
        den     = 1'b1;
        dwe     = 1'b1;
        dcnt_d  = DCW'(1);
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (drp_drdy_i)
          state_d = ST_NEXT;
        else if (dcnt_q == DCW'(DRP_TIMEOUT - 1))
          state_d = ST_FAIL;
        else
          dcnt_d = dcnt_q + 1'b1;
      end
      ST_NEXT: begin
        if (idx_q == IW'(NUM_REGS - 1)) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_ok)
          state_d = ST_DONE;
        else if (lock_to)
          state_d = ST_FAIL;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_FAIL)
      err_d = 1'b1;
    mmcm_rst_d = state_d inside {ST_RD_REQ, ST_RD_WAIT,
                                 ST_WR_REQ, ST_WR_WAIT,
                                 ST_NEXT};
  end

  // Sequencer registers; reset aborts any sequence in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      idx_q      <= '0;
      dcnt_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      mmcm_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      idx_q      <= idx_d;
      dcnt_q     <= dcnt_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      mmcm_rst_q <= mmcm_rst_d;
    end
  end

  assign busy_o      = !(state_q inside {ST_IDLE, ST_FAIL});
  assign done_o      = state_q == ST_DONE;
  assign err_o       = err_q;
  assign mmcm_rst_o  = mmcm_rst_q;
  assign drp_den_o   = den;
  assign drp_dwe_o   = dwe;
  assign drp_daddr_o = den ? entry.addr : 7'h00;
  assign drp_di_o    = dwe ? wdata_q : 16'h0000;

endmodule

// File: tb/tb_rvlab_mmcm_reconfig_ctrl.sv
// Directed bench for the MMCM reconfiguration sequencer.
// A small DRP register model answers 3 cycles after each den.
module tb_rvlab_mmcm_reconfig_ctrl;

  localparam int DRP_TO = 64;
  localparam int LS     = 16;
  localparam int LT     = 300;

  localparam logic [6:0] T_ADDR [8] = '{
    7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h16, 7'h18, 7'h4E};
  localparam logic [15:0] T_MASK [8] = '{
    16'h1000, 16'hFC00, 16'h1000, 16'hFC00,
    16'h1000, 16'hC000, 16'hFC00, 16'h66FF};
  localparam logic [15:0] T_DATA [8] = '{
    16'h028A, 16'h0000, 16'h0083, 16'h0080,
    16'h0145, 16'h1041, 16'h03E8, 16'h0800};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  cfg_sel;
  logic        busy_o, done_o, err_o, mmcm_rst_o;
  logic        drp_den_o, drp_dwe_o;
  logic [6:0]  drp_daddr_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_drdy = 1'b0;
  logic        locked;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] mem [128];
  bit   mem_ok   = 1'b0;
  bit   prev_den = 1'b0;
  int   pend     = 0;
  logic [6:0] pend_addr = 7'h00;
  int   rd_n  = 0;
  int   wr_n  = 0;
  int   den_n = 0;
  int   done_n = 0;
  int   rd_base, wr_base, exp_cfg;
  bit   hang_en;

  always #5 clk = ~clk;

  rvlab_mmcm_reconfig_ctrl #(
    .DRP_TIMEOUT (DRP_TO),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .SEL_W       (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .cfg_sel_i    (cfg_sel),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .mmcm_rst_o   (mmcm_rst_o),
    .drp_den_o    (drp_den_o),
    .drp_dwe_o    (drp_dwe_o),
    .drp_daddr_o  (drp_daddr_o),
    .drp_di_o     (drp_di_o),
    .drp_do_i     (drp_do),
    .drp_drdy_i   (drp_drdy),
    .mmcm_locked_i(locked)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] t_data(input int cfg, input int i);
    if (i == 0)
      return (cfg == 0) ? 16'h028A : 16'h0514;
    return T_DATA[i];
  endfunction

  // DRP register model and per-transaction checks.
  always @(negedge clk) begin : drp_model
    int i;
    if (!mem_ok) begin
      for (int k = 0; k < 128; k++)
        mem[k] = 16'h5A3C ^ (16'(k) * 16'h0111);
      mem_ok = 1'b1;
    end
    drp_drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drp_drdy = 1'b1;
        drp_do   = mem[pend_addr];
      end
    end
    if (drp_den_o) begin
      den_n++;
      chk("den_mmcm_rst", 32'(mmcm_rst_o), 1);
      chk("den_outstanding", pend, 0);
      chk("den_back_to_back", 32'(prev_den), 0);
      if (!drp_dwe_o) begin
        i = (rd_n - rd_base) & 7;
        chk("rd_addr", 32'(drp_daddr_o), 32'(T_ADDR[i]));
        if (!(hang_en && (rd_n - rd_base) == 2)) begin
          pend      = 3;
          pend_addr = drp_daddr_o;
        end
        rd_n++;
      end else begin
        i = (wr_n - wr_base) & 7;
        chk("wr_addr", 32'(drp_daddr_o), 32'(T_ADDR[i]));
        chk("wr_data", 32'(drp_di_o),
            32'((mem[drp_daddr_o] & T_MASK[i]) | t_data(exp_cfg, i)));
        mem[drp_daddr_o] = drp_di_o;
        pend      = 3;
        pend_addr = drp_daddr_o;
        wr_n++;
      end
    end
    prev_den = drp_den_o;
    if (done_o)
      done_n++;
  end

  task automatic snap(input int cfg);
    rd_base = rd_n;
    wr_base = wr_n;
    exp_cfg = cfg;
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    start   = 1'b1;
    cfg_sel = sel;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rst_fall(output int n);
    n = 0;
    while (mmcm_rst_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (mmcm_rst_o) n = -1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) n = -1;
  endtask

  task automatic end_seq(input string tag, input int d0);
    @(negedge clk);
    chk({tag, "_busy_end"}, 32'(busy_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    repeat (4) @(negedge clk);
    chk({tag, "_reads"}, rd_n - rd_base, 8);
    chk({tag, "_writes"}, wr_n - wr_base, 8);
    chk({tag, "_done_cnt"}, done_n - d0, 1);
    locked = 1'b0;
  endtask

  task automatic full_seq(input string tag, input logic [1:0] sel);
    int n, d0;
    d0 = done_n;
    snap(int'(sel));
    pulse_start(sel);
    chk({tag, "_busy"}, 32'(busy_o), 1);
    wait_rst_fall(n);
    chk({tag, "_rst_fall"}, 32'(n >= 0), 1);
    locked = 1'b1;
    wait_done(n);
    chk({tag, "_lock_lat"}, n, LS + 2);
    end_seq(tag, d0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d0, den0;
    rst_n = 1'b0; start = 1'b0; cfg_sel = 2'd0;
    locked = 1'b0; hang_en = 1'b0;
    snap(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_mmcm", 32'(mmcm_rst_o), 0);
    chk("rst_drp", 32'({drp_den_o, drp_dwe_o,
                        drp_daddr_o, drp_di_o}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nominal: LOCKED rises 40 cycles after reset release
    d0 = done_n;
    snap(0);
    pulse_start(2'd0);
    chk("nom_busy", 32'(busy_o), 1);
    chk("nom_mmcm_rst", 32'(mmcm_rst_o), 1);
    wait_rst_fall(n);
    chk("nom_rst_fall", 32'(n >= 0), 1);
    chk("nom_busy_lock", 32'(busy_o), 1);
    repeat (40) @(negedge clk);
    locked = 1'b1;
    wait_done(n);
    chk("nom_lock_lat", n, LS + 2);
    end_seq("nom", d0);

    // lock glitch
    d0 = done_n;
    snap(0);
    pulse_start(2'd0);
    wait_rst_fall(n);
    locked = 1'b1;
    repeat (10) @(negedge clk);
    locked = 1'b0;
    repeat (5) @(negedge clk);
    locked = 1'b1;
    wait_done(n);
    chk("glitch_lock_lat", n, LS + 2);
    end_seq("glitch", d0);

    // DRP hang on the entry 2 read
    d0 = done_n;
    snap(0);
    hang_en = 1'b1;
    pulse_start(2'd0);
    n = 0;
    while (!(drp_den_o && !drp_dwe_o && drp_daddr_o == 7'h0A)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("hang_den_seen", 32'(n < 2000), 1);
    @(negedge clk);
    den0 = den_n;
    repeat (DRP_TO - 2) @(negedge clk);
    chk("hang_err_early", 32'(err_o), 0);
    @(negedge clk);
    chk("hang_err", 32'(err_o), 1);
    chk("hang_mmcm_rst", 32'(mmcm_rst_o), 0);
    chk("hang_busy", 32'(busy_o), 0);
    repeat (20) @(negedge clk);
    chk("hang_no_den", den_n - den0, 0);
    chk("hang_no_done", done_n - d0, 0);
    chk("hang_err_held", 32'(err_o), 1);
    hang_en = 1'b0;

    // new start clears err, config 1 applied
    d0 = done_n;
    snap(1);
    pulse_start(2'd1);
    chk("restart_err_clr", 32'(err_o), 0);
    wait_rst_fall(n);
    locked = 1'b1;
    wait_done(n);
    chk("cfg1_lock_lat", n, LS + 2);
    end_seq("cfg1", d0);

    // invalid selection
    d0 = done_n;
    den0 = den_n;
    pulse_start(2'd3);
    chk("inv_err", 32'(err_o), 1);
    chk("inv_busy", 32'(busy_o), 0);
    chk("inv_mmcm_rst", 32'(mmcm_rst_o), 0);
    repeat (10) @(negedge clk);
    chk("inv_no_den", den_n - den0, 0);
    chk("inv_no_done", done_n - d0, 0);
    chk("inv_err_held", 32'(err_o), 1);

    // start held with another cfg_sel while busy
    d0 = done_n;
    snap(0);
    start = 1'b1;
    cfg_sel = 2'd0;
    @(negedge clk);
    cfg_sel = 2'd1;
    wait_rst_fall(n);
    start = 1'b0;
    locked = 1'b1;
    wait_done(n);
    chk("busy_start_lat", n, LS + 2);
    end_seq("busy_start", d0);

    // reset during WR_WAIT of entry 4
    snap(0);
    pulse_start(2'd0);
    n = 0;
    while (!(drp_den_o && drp_dwe_o && drp_daddr_o == 7'h14)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_den_seen", 32'(n < 2000), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy_o), 0);
    chk("mid_mmcm_rst", 32'(mmcm_rst_o), 0);
    chk("mid_drp", 32'({drp_den_o, drp_dwe_o,
                        drp_daddr_o, drp_di_o}), 0);
    chk("mid_err", 32'(err_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_idle", 32'(busy_o), 0);
    full_seq("after_rst", 2'd0);

    // lock never arrives
    d0 = done_n;
    snap(0);
    pulse_start(2'd0);
    wait_rst_fall(n);
    n = 0;
    while (!err_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("lock_to_lat", n, LT);
    chk("lock_to_busy", 32'(busy_o), 0);
    chk("lock_to_done", done_n - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
